bf_output_decimal_formatter: RTL and testbench

- Downstream of bf_machine; consumes its output word stream over a valid/ready handshake.
- Converts each word to unsigned decimal ASCII: most-significant digit first, leading zeros suppressed, optional terminator character appended.
- Emits one character per accepted handshake on a byte-wide valid/ready stream toward the console/UART side.
- Holds one word at a time and back-pressures bf_machine while converting or emitting.

---
 rtl/bf_output_decimal_formatter.sv | 157 +++++++++++++++
 tb/tb_bf_output_decimal_formatter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf_output_decimal_formatter.sv
// Purpose: converts each accepted WORD_SIZE-bit word into unsigned decimal ASCII
//   (MSD first, leading zeros suppressed, optional terminator) on a byte stream.
// Latency: word accepted at edge T, first character valid after edge T+WORD_SIZE+1;
//   in_ready returns the cycle after the final character transfer.
// Backpressure: in_ready is high only while IDLE; out_char/out_valid are registered
//   and hold stable while out_ready is low.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   in_word/in_valid/in_ready     - word stream from bf_machine
//   out_char/out_valid/out_ready  - ASCII character stream toward console/UART
module bf_output_decimal_formatter #(
  parameter int         WORD_SIZE       = 8,
  parameter int         MAX_DIGITS      = 3,
  parameter int         EMIT_TERMINATOR = 1,
  parameter logic [7:0] TERMINATOR      = 8'h0A
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] in_word,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [7:0]           out_char,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int BW = 4 * MAX_DIGITS;
  localparam int IW = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;
  localparam int CW = $clog2(WORD_SIZE + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CONVERT = 2'd1;
  localparam logic [1:0] S_EMIT    = 2'd2;
  localparam logic [1:0] S_TERM    = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [WORD_SIZE-1:0] word_q, word_d;
  logic [BW-1:0]        bcd_q, bcd_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 out_valid_q, out_valid_d;
  logic [7:0]           out_char_q, out_char_d;

  logic [BW-1:0]        bcd_adj;
  logic [IW-1:0]        msnz;

  // Digits are always 0..9, so the ASCII code is simply {4'h3, nibble}.
  function automatic logic [7:0] digit_char(input logic [BW-1:0] b, input logic [IW-1:0] i);
    logic [3:0] nib;
    nib = b[int'(i) * 4 +: 4];
    return {4'h3, nib};
  endfunction

  // Double-dabble correction: any nibble >= 5 would overflow past 9 after the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Index of the most-significant non-zero digit; 0 when the value is zero so
  // that a lone "0" is still emitted.
  always_comb begin
    msnz = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] != 4'h0) begin
        msnz = IW'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    bcd_d       = bcd_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_char_d  = out_char_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          word_d  = in_word;
          bcd_d   = '0;
          cnt_d   = CW'(WORD_SIZE);
          state_d = S_CONVERT;
        end
      end

      S_CONVERT: begin
        {bcd_d, word_d} = {bcd_adj, word_q} << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_EMIT;
        end
      end

      S_EMIT: begin
        if (!out_valid_q) begin
          // First cycle in EMIT: BCD is final, pick the leading digit.
          idx_d       = msnz;
          out_valid_d = 1'b1;
          out_char_d  = digit_char(bcd_q, msnz);
        end else if (out_ready) begin
          if (idx_q != '0) begin
            idx_d      = idx_q - IW'(1);
            out_char_d = digit_char(bcd_q, idx_q - IW'(1));
          end else if (EMIT_TERMINATOR != 0) begin
            out_char_d = TERMINATOR;
            state_d    = S_TERM;
          end else begin
            out_valid_d = 1'b0;
            out_char_d  = 8'h00;
            state_d     = S_IDLE;
          end
        end
      end

      default: begin // S_TERM
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_char_d  = 8'h00;
          state_d     = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      word_q      <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_char_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      bcd_q       <= bcd_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_char_q  <= out_char_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign out_char  = out_char_q;

endmodule

// File: tb/tb_bf_output_decimal_formatter.sv
module tb_bf_output_decimal_formatter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_word;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_char;
  logic       out_valid;
  logic       out_ready;

  logic [7:0] in_word2;
  logic       in_valid2;
  logic       in_ready2;
  logic [7:0] out_char2;
  logic       out_valid2;
  logic       out_ready2;

  bf_output_decimal_formatter #(
    .WORD_SIZE(8), .MAX_DIGITS(3), .EMIT_TERMINATOR(1), .TERMINATOR(8'h0A)
  ) dut (
    .clk(clk), .rst(rst),
    .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready),
    .out_char(out_char), .out_valid(out_valid), .out_ready(out_ready)
  );

  bf_output_decimal_formatter #(
    .WORD_SIZE(8), .MAX_DIGITS(3), .EMIT_TERMINATOR(0), .TERMINATOR(8'h0A)
  ) dut_noterm (
    .clk(clk), .rst(rst),
    .in_word(in_word2), .in_valid(in_valid2), .in_ready(in_ready2),
    .out_char(out_char2), .out_valid(out_valid2), .out_ready(out_ready2)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int         first_vld_k;
  int         rdy_k;
  bit         tmo;

  // Inputs are driven and outputs sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (!in_ready && g < 50) begin
      step();
      g++;
    end
    if (!in_ready) tmo = 1'b1;
  endtask

  // Present one word on the main DUT and record the resulting characters,
  // the cycle of the first out_valid and the cycle in_ready returns
  // (k counts samples after the accepting edge T).
  task automatic run_word(input logic [7:0] w);
    got.delete();
    first_vld_k = -1;
    rdy_k       = -1;
    tmo         = 1'b0;
    out_ready   = 1'b1;
    wait_idle();
    in_word  = w;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_word  = 8'hA5;
    for (int k = 0; k < 60; k++) begin
      if (out_valid && first_vld_k < 0) first_vld_k = k;
      if (out_valid && out_ready) got.push_back(out_char);
      if (in_ready) begin
        rdy_k = k;
        break;
      end
      step();
    end
    if (rdy_k < 0) tmo = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_word = 8'h00; out_ready = 1'b0;
    in_valid2 = 1'b0; in_word2 = 8'h00; out_ready2 = 1'b0;
    step(); step();
    rst = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_char !== 8'h00) begin bad++; $display("FAIL reset_out_char got=%h want=00", out_char); end
  endtask

  task automatic test_three();
    run_word(8'd3);
    exp_q = '{8'h33, 8'h0A};
    total++; if (tmo) begin bad++; $display("FAIL three_timeout got=timeout want=done"); end
    total++; if (first_vld_k !== 9) begin bad++; $display("FAIL three_first_valid got=%0d want=9", first_vld_k); end
    total++; if (rdy_k !== 11) begin bad++; $display("FAIL three_ready_back got=%0d want=11", rdy_k); end
    total++; if (got.size() !== exp_q.size()) begin bad++; $display("FAIL three_count got=%0d want=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got.size() || got[i] !== exp_q[i]) begin
        bad++; $display("FAIL three_char%0d got=%h want=%h", i, (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_255();
    run_word(8'd255);
    exp_q = '{8'h32, 8'h35, 8'h35, 8'h0A};
    total++; if (tmo) begin bad++; $display("FAIL w255_timeout got=timeout want=done"); end
    // four transfers back-to-back: load after T+9, last transfer at T+13
    total++; if (rdy_k !== 13) begin bad++; $display("FAIL w255_no_bubble got=%0d want=13", rdy_k); end
    total++; if (got.size() !== exp_q.size()) begin bad++; $display("FAIL w255_count got=%0d want=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got.size() || got[i] !== exp_q[i]) begin
        bad++; $display("FAIL w255_char%0d got=%h want=%h", i, (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_zero_and_100();
    run_word(8'd0);
    exp_q = '{8'h30, 8'h0A};
    total++; if (tmo || got.size() !== 2) begin bad++; $display("FAIL zero_count got=%0d want=2", got.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got.size() || got[i] !== exp_q[i]) begin
        bad++; $display("FAIL zero_char%0d got=%h want=%h", i, (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
      end
    end
    run_word(8'd100);
    exp_q = '{8'h31, 8'h30, 8'h30, 8'h0A};
    total++; if (tmo || got.size() !== 4) begin bad++; $display("FAIL w100_count got=%0d want=4", got.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got.size() || got[i] !== exp_q[i]) begin
        bad++; $display("FAIL w100_char%0d got=%h want=%h", i, (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0] prev_char;
    bit         prev_vld;
    bit         prev_xfer;
    bit         xfer;
    bit         done;
    got.delete();
    tmo = 1'b0; done = 1'b0;
    prev_vld = 1'b0; prev_xfer = 1'b0; prev_char = 8'h00;
    out_ready = 1'b1;
    wait_idle();
    in_word = 8'd209; in_valid = 1'b1;
    step();
    in_valid = 1'b0; in_word = 8'h5A;
    for (int c = 0; c < 120; c++) begin
      out_ready = (c % 3 == 0);
      if (out_valid && prev_vld && !prev_xfer) begin
        total++;
        if (out_char !== prev_char) begin
          bad++; $display("FAIL stall_hold c=%0d got=%h want=%h", c, out_char, prev_char);
        end
      end
      xfer = out_valid && out_ready;
      if (xfer) got.push_back(out_char);
      prev_vld = out_valid; prev_xfer = xfer; prev_char = out_char;
      if (c > 0 && in_ready) begin
        done = 1'b1;
        break;
      end
      step();
    end
    out_ready = 1'b1;
    exp_q = '{8'h32, 8'h30, 8'h39, 8'h0A};
    total++; if (tmo || !done) begin bad++; $display("FAIL stall_timeout got=timeout want=done"); end
    total++; if (got.size() !== 4) begin bad++; $display("FAIL stall_count got=%0d want=4", got.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got.size() || got[i] !== exp_q[i]) begin
        bad++; $display("FAIL stall_char%0d got=%h want=%h", i, (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [3];
    int         idx;
    int         accepts;
    int         end_c;
    bit         acc;
    words = '{8'd3, 8'd9, 8'd5};
    got.delete();
    tmo = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    idx = 0; accepts = 0; end_c = -1;
    in_word = words[0]; in_valid = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (out_valid && out_ready) got.push_back(out_char);
      if (accepts == 3 && in_ready) begin
        end_c = c;
        break;
      end
      acc = in_ready && in_valid;
      step();
      if (acc) begin
        accepts++;
        idx++;
        if (idx < 3) in_word = words[idx];
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    exp_q = '{8'h33, 8'h0A, 8'h39, 8'h0A, 8'h35, 8'h0A};
    // each word occupies 1+8+1+digits+1 = 12 cycles
    total++; if (end_c !== 36) begin bad++; $display("FAIL b2b_cycles got=%0d want=36", end_c); end
    total++; if (got.size() !== exp_q.size()) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got.size() || got[i] !== exp_q[i]) begin
        bad++; $display("FAIL b2b_char%0d got=%h want=%h", i, (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int g;
    tmo = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    in_word = 8'd255; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    g = 0;
    while (!out_valid && g < 30) begin
      step();
      g++;
    end
    total++; if (!out_valid) begin bad++; $display("FAIL rstmid_first_digit got=%b want=1", out_valid); end
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_out_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready got=%b want=1", in_ready); end
    run_word(8'd7);
    exp_q = '{8'h37, 8'h0A};
    total++; if (tmo || got.size() !== 2) begin bad++; $display("FAIL rstmid_count got=%0d want=2", got.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got.size() || got[i] !== exp_q[i]) begin
        bad++; $display("FAIL rstmid_char%0d got=%h want=%h", i, (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_noterm();
    int k_rdy;
    got.delete();
    k_rdy = -1;
    out_ready2 = 1'b1;
    in_word2 = 8'd42; in_valid2 = 1'b1;
    total++; if (in_ready2 !== 1'b1) begin bad++; $display("FAIL noterm_idle got=%b want=1", in_ready2); end
    step();
    in_valid2 = 1'b0; in_word2 = 8'hFF;
    for (int k = 0; k < 40; k++) begin
      if (out_valid2 && out_ready2) got.push_back(out_char2);
      if (in_ready2) begin
        k_rdy = k;
        break;
      end
      step();
    end
    exp_q = '{8'h34, 8'h32};
    total++; if (k_rdy !== 11) begin bad++; $display("FAIL noterm_ready_back got=%0d want=11", k_rdy); end
    total++; if (got.size() !== 2) begin bad++; $display("FAIL noterm_count got=%0d want=2", got.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got.size() || got[i] !== exp_q[i]) begin
        bad++; $display("FAIL noterm_char%0d got=%h want=%h", i, (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_three();
    test_255();
    test_zero_and_100();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_noterm();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
